// File: rtl/esc_setpoint_sequencer.sv
// Slews the ESC period setpoint toward host targets, passing through zero on a direction change, and latches a stall fault.
// Latency: period_ref_o updates one clock after an accept or tick; cmd_ready is low in STOP, in FAULT, or while disabled.
module esc_setpoint_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int TICK_DIV   = 65
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic signed [DATA_WIDTH-1:0] cmd_period,
  input  logic        [DATA_WIDTH-1:0] ramp_step,
  input  logic        [DATA_WIDTH-1:0] stall_limit,
  input  logic                         fault_clr,
  input  logic        [DATA_WIDTH-1:0] period_speed,
  output logic signed [DATA_WIDTH-1:0] period_ref_o,
  output logic                         pwm_en_o,
  output logic                         at_target,
  output logic                         fault_o,
  output logic        [2:0]            state_o
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    HOLD  = 3'd2,
    STOP  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t                         state, state_nxt;
  logic signed [DATA_WIDTH-1:0]   ref_q, ref_nxt, target, target_nxt, stepped;
  logic        [DATA_WIDTH-1:0]   stall_cnt, stall_nxt, last_speed, step_eff;
  logic        [CW-1:0]           tick_cnt;
  logic                           tick, accept, stalled, stepping, active_nxt;

  // Move cur toward goal by at most step; the DW+1-bit difference keeps the compare free of wrap.
  function automatic logic signed [DATA_WIDTH-1:0] slew(
    input logic signed [DATA_WIDTH-1:0] cur,
    input logic signed [DATA_WIDTH-1:0] goal,
    input logic        [DATA_WIDTH-1:0] step
  );
    logic signed [DATA_WIDTH:0] diff;
    logic signed [DATA_WIDTH:0] mag;
    diff = {goal[DATA_WIDTH-1], goal} - {cur[DATA_WIDTH-1], cur};
    mag  = diff[DATA_WIDTH] ? -diff : diff;
    if (mag <= $signed({1'b0, step})) return goal;
    else if (diff[DATA_WIDTH])        return cur - step;
    else                              return cur + step;
  endfunction

  assign tick      = (tick_cnt == CW'(TICK_DIV - 1));
  assign cmd_ready = reset & enable & ((state == IDLE) || (state == RAMP) || (state == HOLD));
  assign accept    = cmd_valid & cmd_ready;
  assign step_eff  = (ramp_step == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : ramp_step;
  assign stepping  = tick & ((state == RAMP) || (state == STOP));
  assign stalled   = pwm_en_o & (stall_limit != '0) & (stall_cnt >= stall_limit);
  assign stepped   = slew(ref_q, (state == STOP) ? '0 : target, step_eff);

  always_comb begin
    state_nxt  = state;
    ref_nxt    = ref_q;
    target_nxt = target;
    if (state == FAULT) begin
      ref_nxt = '0;
      if (fault_clr) begin
        state_nxt  = IDLE;
        target_nxt = '0;
      end
    end else if (!enable) begin
      state_nxt  = IDLE;
      ref_nxt    = '0;
      target_nxt = '0;
    end else begin
      if (accept) target_nxt = cmd_period;
      if (stalled) begin
        state_nxt = FAULT;
        ref_nxt   = '0;
      end else begin
        // A step coinciding with an accept still heads for the old goal.
        if (stepping) begin
          ref_nxt = stepped;
          if ((state == RAMP) && (stepped == target)) state_nxt = (target == '0) ? IDLE : HOLD;
          if ((state == STOP) && (stepped == '0))     state_nxt = RAMP;
        end
        if (accept) begin
          if ((ref_q != '0) && (cmd_period != '0) &&
              (cmd_period[DATA_WIDTH-1] != ref_q[DATA_WIDTH-1])) state_nxt = STOP;
          else if (cmd_period != ref_q)                          state_nxt = RAMP;
          else if ((state == IDLE) && (cmd_period == '0))        state_nxt = IDLE;
          else                                                   state_nxt = stepping ? RAMP : HOLD;
        end
      end
    end
  end

  assign active_nxt = (state_nxt == RAMP) || (state_nxt == HOLD) || (state_nxt == STOP);

  always_comb begin
    stall_nxt = stall_cnt;
    if (!active_nxt) begin
      stall_nxt = '0;
    end else if (tick && pwm_en_o && (stall_limit != '0)) begin
      if (period_speed != last_speed) stall_nxt = '0;
      else if (stall_cnt != '1)       stall_nxt = stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ref_q      <= '0;
      target     <= '0;
      pwm_en_o   <= 1'b0;
      tick_cnt   <= '0;
      stall_cnt  <= '0;
      last_speed <= '0;
    end else begin
      state     <= state_nxt;
      ref_q     <= ref_nxt;
      target    <= target_nxt;
      pwm_en_o  <= active_nxt;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      stall_cnt <= stall_nxt;
      if (tick) last_speed <= period_speed;
    end
  end

  assign period_ref_o = ref_q;
  assign at_target    = (state == HOLD) && (ref_q == target);
  assign fault_o      = (state == FAULT);
  assign state_o      = state;

endmodule

// File: tb/tb_esc_setpoint_sequencer.sv
// Directed scenarios followed by random traffic, every clock compared against a behavioural model.
module tb_esc_setpoint_sequencer;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, enable, cmd_valid, cmd_ready, fault_clr;
  logic          pwm_en_o, at_target, fault_o;
  logic [DW-1:0] cmd_period, ramp_step, stall_limit, period_speed, period_ref_o;
  logic [2:0]    state_o;

  int checks = 0;
  int errors = 0;

  // Model: state 0..4 = IDLE, RAMP, HOLD, STOP, FAULT.
  int m_state, m_ref, m_tgt, m_stall, m_last, m_cnt;
  bit m_pwm, m_ticked;

  always #5 clk = ~clk;

  esc_setpoint_sequencer #(.DATA_WIDTH(DW), .TICK_DIV(65)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .ramp_step(ramp_step), .stall_limit(stall_limit), .fault_clr(fault_clr),
    .period_speed(period_speed), .period_ref_o(period_ref_o), .pwm_en_o(pwm_en_o),
    .at_target(at_target), .fault_o(fault_o), .state_o(state_o)
  );

  function automatic int dref();
    return int'($signed(period_ref_o));
  endfunction

  function automatic int exp_ready();
    return (reset && enable && m_state <= 2) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ref = 0; m_tgt = 0; m_stall = 0; m_last = 0; m_cnt = 0;
    m_pwm = 0; m_ticked = 0;
  endtask

  task automatic model_clk();
    int cmd, s, goal, d, nref, nstate, ntgt, lim;
    bit tk, acc, stalled, stepping;
    tk       = (m_cnt == 64);
    cmd      = int'($signed(cmd_period));
    lim      = int'(stall_limit);
    acc      = cmd_valid && (exp_ready() == 1);
    stalled  = m_pwm && lim != 0 && m_stall >= lim;
    stepping = tk && (m_state == 1 || m_state == 3);
    nstate = m_state; nref = m_ref; ntgt = m_tgt;
    if (m_state == 4) begin
      nref = 0;
      if (fault_clr) begin nstate = 0; ntgt = 0; end
    end else if (!enable) begin
      nstate = 0; nref = 0; ntgt = 0;
    end else begin
      if (acc) ntgt = cmd;
      if (stalled) begin
        nstate = 4; nref = 0;
      end else begin
        if (stepping) begin
          goal = (m_state == 3) ? 0 : m_tgt;
          s    = (ramp_step == 0) ? 1 : int'(ramp_step);
          d    = goal - m_ref;
          if (d <= s && d >= -s) nref = goal;
          else nref = m_ref + ((d > 0) ? s : -s);
          if (m_state == 1 && nref == m_tgt) nstate = (m_tgt == 0) ? 0 : 2;
          if (m_state == 3 && nref == 0) nstate = 1;
        end
        if (acc) begin
          if (m_ref != 0 && cmd != 0 && ((cmd < 0) != (m_ref < 0))) nstate = 3;
          else if (cmd != m_ref) nstate = 1;
          else if (m_state == 0 && cmd == 0) nstate = 0;
          else nstate = stepping ? 1 : 2;
        end
      end
    end
    if (!(nstate >= 1 && nstate <= 3)) m_stall = 0;
    else if (tk && m_pwm && lim != 0)
      m_stall = (int'(period_speed) == m_last) ? ((m_stall < 65535) ? m_stall + 1 : m_stall) : 0;
    if (tk) m_last = int'(period_speed);
    m_cnt    = tk ? 0 : m_cnt + 1;
    m_ticked = tk;
    m_state  = nstate; m_ref = nref; m_tgt = ntgt;
    m_pwm    = (nstate >= 1 && nstate <= 3);
  endtask

  task automatic check_all();
    chk("state", int'(state_o), m_state);
    chk("period_ref", dref(), m_ref);
    chk("pwm_en", int'(pwm_en_o), int'(m_pwm));
    chk("at_target", int'(at_target), (m_state == 2 && m_ref == m_tgt) ? 1 : 0);
    chk("fault", int'(fault_o), (m_state == 4) ? 1 : 0);
    chk("cmd_ready", int'(cmd_ready), exp_ready());
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_clk();
      #1;
      check_all();
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    m_ticked = 0;
    while (!m_ticked && n < 70) begin
      cyc(1);
      n++;
    end
    chk("tick_seen", int'(m_ticked), 1);
  endtask

  task automatic send(input int v);
    cmd_valid  = 1'b1;
    cmd_period = v[DW-1:0];
    cyc(1);
    cmd_valid  = 1'b0;
  endtask

  initial begin
    int exp2 [5];
    exp2 = '{60, 20, 0, -40, -50};
    reset = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_period = '0; fault_clr = 1'b0;
    ramp_step = 16'd10; stall_limit = '0; period_speed = 16'd500;
    model_reset();
    #12;
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_ref", dref(), 0);
    chk("rst_state", int'(state_o), 0);
    chk("rst_pwm", int'(pwm_en_o), 0);
    #1 reset = 1'b1;
    cyc(3);

    // 1: ramp 0 -> +100 in steps of 10
    send(100);
    for (int k = 1; k <= 10; k++) begin
      wait_tick();
      chk("t1_ref", dref(), 10 * k);
      chk("t1_pwm", int'(pwm_en_o), 1);
    end
    cyc(1);
    chk("t1_hold", int'(state_o), 2);
    chk("t1_at_target", int'(at_target), 1);

    // 2: reversal through zero
    ramp_step = 16'd40;
    send(-50);
    chk("t2_stop", int'(state_o), 3);
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      chk("t2_ref", dref(), exp2[k]);
    end
    cyc(1);
    chk("t2_hold", int'(state_o), 2);

    // 3: zero step treated as one
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    ramp_step = '0;
    send(3);
    for (int k = 1; k <= 3; k++) begin
      wait_tick();
      chk("t3_up", dref(), k);
    end
    chk("t3_hold", int'(state_o), 2);
    send(0);
    for (int k = 2; k >= 0; k--) begin
      wait_tick();
      chk("t3_down", dref(), k);
    end
    chk("t3_idle", int'(state_o), 0);
    chk("t3_pwm", int'(pwm_en_o), 0);

    // 4: stall fault and clear
    ramp_step = 16'd10; stall_limit = 16'd4;
    send(20);
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      chk("t4_no_fault", int'(fault_o), 0);
    end
    cyc(1);
    chk("t4_fault_state", int'(state_o), 4);
    chk("t4_fault_ref", dref(), 0);
    chk("t4_fault_pwm", int'(pwm_en_o), 0);
    chk("t4_fault_ready", int'(cmd_ready), 0);
    cyc(5);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    chk("t4_clr_idle", int'(state_o), 0);
    stall_limit = '0;
    send(20);
    for (int k = 0; k < 8; k++) wait_tick();
    chk("t4_disabled", int'(fault_o), 0);

    // 5: enable drop, coincident accept, async reset
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    send(200);
    wait_tick();
    wait_tick();
    enable = 1'b0;
    cyc(1);
    chk("t5_en_state", int'(state_o), 0);
    chk("t5_en_ref", dref(), 0);
    enable = 1'b1;
    send(100);
    for (int k = 0; k < 3; k++) wait_tick();
    chk("t5_mid", dref(), 30);
    for (int i = 0; i < 70 && m_cnt != 64; i++) cyc(1);
    send(50);
    chk("t5_old_goal", dref(), 40);
    wait_tick();
    chk("t5_new_goal", dref(), 50);
    chk("t5_hold", int'(state_o), 2);
    send(-100);
    wait_tick();
    chk("t5_stop_ref", dref(), 40);
    chk("t5_stop_state", int'(state_o), 3);
    #3 reset = 1'b0;
    #1;
    chk("t5_arst_ref", dref(), 0);
    chk("t5_arst_state", int'(state_o), 0);
    chk("t5_arst_pwm", int'(pwm_en_o), 0);
    chk("t5_arst_ready", int'(cmd_ready), 0);
    chk("t5_arst_fault", int'(fault_o), 0);
    chk("t5_arst_at", int'(at_target), 0);
    model_reset();
    #1 reset = 1'b1;

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      int v;
      v = int'($urandom_range(0, 600)) - 300;
      cmd_valid  = ($urandom_range(0, 15) == 0);
      cmd_period = v[DW-1:0];
      if ($urandom_range(0, 199) == 0) ramp_step = 16'($urandom_range(0, 60));
      if ($urandom_range(0, 299) == 0) stall_limit = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) period_speed = 16'($urandom);
      enable    = ($urandom_range(0, 399) != 0);
      fault_clr = ($urandom_range(0, 99) == 0);
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
